// File: rtl/sata_dma_mem_sequencer.sv
// Memory-side burst sequencer for SATA DMA (AXI-HP domain).
// Splits a sector command into 128-byte, 16-beat bursts.
module sata_dma_mem_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             hclk,
    input  logic             rst,
    input  logic [24:0]      cmd_addr,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_type,
    input  logic             cmd_val,
    output logic             cmd_busy,
    output logic             cmd_done,
    output logic [24:0]      req_addr,
    output logic             req_write,
    output logic             req_val,
    input  logic             req_ack,
    output logic [63:0]      mem_wdata,
    output logic             mem_wval,
    output logic             mem_wlast,
    input  logic             mem_wready,
    input  logic [63:0]      mem_rdata,
    input  logic             mem_rval,
    output logic             mem_rready,
    input  logic [63:0]      to_data,
    input  logic             to_val,
    output logic             to_ack,
    output logic [63:0]      from_data,
    output logic             from_val,
    input  logic             from_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } state_t;

    localparam logic [CNT_W+1:0] ONE_BURST = 1;

    state_t           state;
    state_t           state_nx;
    logic [24:0]      addr_r;
    logic             type_r;
    logic [CNT_W+1:0] bursts_r;
    logic [3:0]       beat_r;
    logic             beat_done;
    logic             last_beat;

    assign last_beat = beat_done && (beat_r == 4'd15);

    // State register
    always_ff @(posedge hclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Command latch, burst address and beat/burst counters
    always_ff @(posedge hclk) begin
        if (rst) begin
            addr_r   <= '0;
            type_r   <= 1'b0;
            bursts_r <= '0;
            beat_r   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_val) begin
                        addr_r   <= cmd_addr;
                        type_r   <= cmd_type;
                        bursts_r <= {cmd_cnt, 2'b00};
                    end
                end
                REQ: begin
                    if (req_ack) begin
                        addr_r <= addr_r + 25'd1;
                        beat_r <= '0;
                    end
                end
                DATA: begin
                    if (beat_done) begin
                        beat_r <= beat_r + 4'd1;
                    end
                    if (last_beat) begin
                        bursts_r <= bursts_r - ONE_BURST;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state, request and pass-through data handshakes
    always_comb begin
        state_nx   = state;
        cmd_busy   = (state != IDLE);
        cmd_done   = (state == DONE);
        req_val    = 1'b0;
        req_addr   = '0;
        req_write  = 1'b0;
        mem_wdata  = '0;
        mem_wval   = 1'b0;
        mem_wlast  = 1'b0;
        to_ack     = 1'b0;
        from_data  = '0;
        from_val   = 1'b0;
        mem_rready = 1'b0;
        beat_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_val) begin
                    state_nx = (cmd_cnt == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                req_val   = 1'b1;
                req_addr  = addr_r;
                req_write = type_r;
                if (req_ack) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (type_r) begin
                    mem_wdata = to_data;
                    mem_wval  = to_val;
                    mem_wlast = (beat_r == 4'd15);
                    to_ack    = to_val & mem_wready;
                    beat_done = to_val & mem_wready;
                end else begin
                    from_data  = mem_rdata;
                    from_val   = mem_rval;
                    mem_rready = from_ack;
                    beat_done  = mem_rval & from_ack;
                end
                if (last_beat) begin
                    state_nx = (bursts_r == ONE_BURST) ? DONE : REQ;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
